// File: rtl/seq0356_pkg.sv
// Shared code table, FSM state type and code helpers for the 0-3-5-6 sequence checker.
package seq0356_pkg;

    localparam logic [3:0] C0 = 4'd0;
    localparam logic [3:0] C1 = 4'd3;
    localparam logic [3:0] C2 = 4'd5;
    localparam logic [3:0] C3 = 4'd6;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED, LOSS} state_t;

    // Illegal codes map to C0; callers only use the result for legal codes.
    function automatic logic [3:0] next_code(input logic [3:0] c);
        case (c)
            C0:      next_code = C1;
            C1:      next_code = C2;
            C2:      next_code = C3;
            C3:      next_code = C0;
            default: next_code = C0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] c);
        is_legal = (c == C0) || (c == C1) || (c == C2) || (c == C3);
    endfunction

    function automatic logic [1:0] decode(input logic [3:0] c);
        case (c)
            C1:      decode = 2'd1;
            C2:      decode = 2'd2;
            C3:      decode = 2'd3;
            default: decode = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seq_checker_0356_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_checker_0356.sv
// Receive-side checker for the 0-3-5-6 code stream: decodes, acquires lock,
// flags sequence errors with a flywheel expected code, and drops lock on repeated errors.
module seq_checker_0356
    import seq0356_pkg::*;
#(
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [3:0]           code,
    output logic [1:0]           idx,
    output logic                 idx_valid,
    output logic                 locked,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [3:0] LOCK_CNT_4  = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_E_4  = 4'(UNLOCK_ERRS);

    state_t     state_q, state_d;
    logic [3:0] good_cnt_q, good_cnt_d;
    logic [3:0] bad_cnt_q, bad_cnt_d;
    logic [3:0] exp_code_q, exp_code_d;
    logic [1:0] idx_q, idx_d;
    logic       idx_valid_q, idx_valid_d;
    logic       err_q, err_d;
    logic       err_sticky_q, err_sticky_d;

    logic legal;
    logic correct;

    assign legal   = is_legal(code);
    assign correct = legal && (code == exp_code_q);

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= HUNT;
            good_cnt_q   <= '0;
            bad_cnt_q    <= '0;
            exp_code_q   <= C0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            exp_code_q   <= exp_code_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        exp_code_d = exp_code_q;
        if (valid) begin
            case (state_q)
                HUNT: begin
                    if (legal) begin
                        state_d    = SYNC;
                        good_cnt_d = 4'd1;
                        exp_code_d = next_code(code);
                    end
                end
                SYNC: begin
                    if (correct) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        exp_code_d = next_code(code);
                        if ((good_cnt_q + 4'd1) == LOCK_CNT_4) begin
                            state_d   = LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else if (legal) begin
                        good_cnt_d = 4'd1;
                        exp_code_d = next_code(code);
                    end else begin
                        state_d    = HUNT;
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (correct) begin
                        exp_code_d = next_code(code);
                    end else begin
                        // Flywheel: advance the expectation as if the right code had arrived.
                        exp_code_d = next_code(exp_code_q);
                        if (UNLOCK_ERRS == 1) begin
                            state_d    = HUNT;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end else begin
                            state_d   = LOSS;
                            bad_cnt_d = 4'd1;
                        end
                    end
                end
                LOSS: begin
                    if (correct) begin
                        state_d    = LOCKED;
                        bad_cnt_d  = '0;
                        exp_code_d = next_code(code);
                    end else begin
                        exp_code_d = next_code(exp_code_q);
                        bad_cnt_d  = bad_cnt_q + 4'd1;
                        if ((bad_cnt_q + 4'd1) == UNLOCK_E_4) begin
                            state_d    = HUNT;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        if (valid) begin
            if (legal) begin
                idx_d       = decode(code);
                idx_valid_d = 1'b1;
            end
            if (((state_q == LOCKED) || (state_q == LOSS)) && !correct) begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
            end
        end
    end

    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .clear (clear),
        .inc   (err_d),
        .count (err_count)
    );

    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign locked     = (state_q == LOCKED) || (state_q == LOSS);
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_seq_checker_0356.sv
// Directed vector bench: default-parameter checker driven from a table, plus a
// narrow-counter instance for error-count saturation.
module tb_seq_checker_0356;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear_a, valid_a;
    logic [3:0] code_a;
    logic [1:0] idx_a;
    logic       idx_valid_a, locked_a, err_a, err_sticky_a;
    logic [7:0] err_count_a;

    logic       clear_b, valid_b;
    logic [3:0] code_b;
    logic [1:0] idx_b;
    logic       idx_valid_b, locked_b, err_b, err_sticky_b;
    logic [1:0] err_count_b;

    seq_checker_0356 #(.LOCK_COUNT(4), .UNLOCK_ERRS(2), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .clear(clear_a), .valid(valid_a), .code(code_a),
        .idx(idx_a), .idx_valid(idx_valid_a), .locked(locked_a),
        .err(err_a), .err_sticky(err_sticky_a), .err_count(err_count_a)
    );

    seq_checker_0356 #(.LOCK_COUNT(4), .UNLOCK_ERRS(15), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .clear(clear_b), .valid(valid_b), .code(code_b),
        .idx(idx_b), .idx_valid(idx_valid_b), .locked(locked_b),
        .err(err_b), .err_sticky(err_sticky_b), .err_count(err_count_b)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic [3:0] code;
        logic [1:0] idx;
        logic       iv;
        logic       lk;
        logic       er;
        logic       st;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic clr, input logic vld, input logic [3:0] code,
                                input logic [1:0] idx, input logic iv, input logic lk,
                                input logic er, input logic st, input logic [7:0] cnt);
        vec_t v;
        v.clr = clr; v.vld = vld; v.code = code; v.idx = idx; v.iv = iv;
        v.lk = lk; v.er = er; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input int act, input int exp);
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at step %0d: got %0d, want %0d", nm, row, act, exp);
        end
    endtask

    task automatic drive_b(input logic clr, input logic vld, input logic [3:0] c);
        @(negedge clk);
        clear_b = clr; valid_b = vld; code_b = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_a = 1'b0; valid_a = 1'b0; code_a = '0;
        clear_b = 1'b1; valid_b = 1'b0; code_b = '0;

        //            clr vld code idx iv lk er st cnt
        // acquisition
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6, 3, 1, 1, 0, 0, 0));
        // single error with flywheel: 0,3,9,6,0
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 1, 0, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 6, 3, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 1));
        // valid gap: FSM holds, idx holds, idx_valid low
        tbl.push_back(mk(0, 0, 5, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3, 1, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 5, 2, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 6, 3, 1, 1, 0, 1, 1));
        // loss of lock: 0,3,0,0
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 3, 1, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 1, 1, 2));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 3));
        // re-lock, count unchanged
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 1, 3));
        tbl.push_back(mk(0, 1, 5, 2, 1, 0, 0, 1, 3));
        tbl.push_back(mk(0, 1, 6, 3, 1, 1, 0, 1, 3));
        // clear beats valid in the same cycle
        tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0));
        // acquisition restart: 0,3,6,0,3,5
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 2, 1, 1, 0, 0, 0));
        // illegal codes in HUNT/SYNC are never counted
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 15, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 2, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            clear_a = tbl[i].clr; valid_a = tbl[i].vld; code_a = tbl[i].code;
            @(posedge clk);
            #1;
            n_vec++;
            chk("idx",        i, int'(idx_a),        int'(tbl[i].idx));
            chk("idx_valid",  i, int'(idx_valid_a),  int'(tbl[i].iv));
            chk("locked",     i, int'(locked_a),     int'(tbl[i].lk));
            chk("err",        i, int'(err_a),        int'(tbl[i].er));
            chk("err_sticky", i, int'(err_sticky_a), int'(tbl[i].st));
            chk("err_count",  i, int'(err_count_a),  int'(tbl[i].cnt));
        end
        @(negedge clk);
        valid_a = 1'b0;

        // saturation on a 2-bit counter, lock held through 5 errors
        drive_b(1, 0, 0);
        n_vec++;
        chk("sat_reset_count", 0, int'(err_count_b), 0);
        drive_b(0, 1, 0);
        drive_b(0, 1, 3);
        drive_b(0, 1, 5);
        drive_b(0, 1, 6);
        n_vec++;
        chk("sat_locked", 0, int'(locked_b), 1);
        for (int k = 1; k <= 5; k++) begin
            drive_b(0, 1, 9);
            n_vec++;
            chk("sat_err",        k, int'(err_b),        1);
            chk("sat_err_count",  k, int'(err_count_b),  (k < 3) ? k : 3);
            chk("sat_err_sticky", k, int'(err_sticky_b), 1);
            chk("sat_locked",     k, int'(locked_b),     1);
        end
        drive_b(0, 0, 0);
        n_vec++;
        chk("sat_err_idle", 6, int'(err_b), 0);
        chk("sat_hold",     6, int'(err_count_b), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_checker_0356.md
Name: seq_checker_0356

Overview:
- Receive-side checker for the 4-bit code stream produced by the 0→3→5→6 synchronous counter.
- Samples the code each valid cycle and decodes it to a 2-bit index.
- Acquires lock on the sequence, flags and counts sequence errors, and drops lock after repeated errors.
- Sits downstream of the counter, or of any link that carries its code, as a monitor/decoder.

Parameters:
- LOCK_COUNT, 4: consecutive correct legal samples needed to reach LOCKED (range 2..15).
- UNLOCK_ERRS, 2: consecutive errors while locked that force a return to HUNT (range 1..15).
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- clear  input  1  reset; synchronous, active-high.
- valid  input  1  code is sampled this cycle.
- code  input  4  {q3,q2,q1,q0} from the counter.
- idx  output  2  decoded index: 0→0, 3→1, 5→2, 6→3.
- idx_valid  output  1  idx is valid; registered.
- locked  output  1  high in LOCKED and LOSS states.
- err  output  1  one-cycle pulse per counted sequence error.
- err_sticky  output  1  set by err; cleared only by clear.
- err_count  output  ERR_CNT_W  number of counted errors; saturates at all-ones.

Behaviour:
- Reset: clear is sampled on the clk edge and wins over valid in the same cycle. It sets state=HUNT, good_cnt=0, bad_cnt=0, exp_code=0, and drives idx=0, idx_valid=0, locked=0, err=0, err_sticky=0, err_count=0. Asserting clear mid-stream aborts everything in the next cycle; no partial updates.
- Legality and successor:
  - Legal codes: 0, 3, 5, 6. All others are illegal.
  - next(0)=3, next(3)=5, next(5)=6, next(6)=0.
  - A sample is correct when it is legal and equals exp_code.
- Latency: every output is registered, one cycle after the sampled valid.
- idx_valid=1 iff the sample was valid and legal; idx holds the decode.
- Illegal or non-valid sample: idx_valid=0 and idx holds its previous value.
- valid=0: the FSM, counters and exp_code hold; err=0.
- FSM, evaluated only when valid=1:
  - HUNT:
    - Legal code → SYNC, good_cnt=1, exp_code=next(code).
    - Illegal → stay in HUNT.
    - No errors are counted.
  - SYNC:
    - Correct → good_cnt+1 and exp_code=next(code). If the new good_cnt==LOCK_COUNT → LOCKED, bad_cnt=0.
    - Legal but wrong → restart: good_cnt=1, exp_code=next(code).
    - Illegal → HUNT, good_cnt=0.
    - No errors are counted.
  - LOCKED:
    - Correct → stay, exp_code=next(code).
    - Error (illegal, or legal but wrong) → err pulse, err_count+1 (saturating), err_sticky=1, exp_code=next(exp_code) (flywheel), bad_cnt=1. Go to LOSS, or to HUNT if UNLOCK_ERRS==1.
  - LOSS:
    - Correct → LOCKED, bad_cnt=0, exp_code=next(code).
    - Error → err pulse, count, flywheel, bad_cnt+1. If the new bad_cnt==UNLOCK_ERRS → HUNT, good_cnt=0, bad_cnt=0.
- locked=1 in LOCKED and LOSS. It drops in the cycle after the HUNT transition.
- Errors are counted on the sample that causes the exit to HUNT, and in no state other than LOCKED or LOSS.
- err_count saturation: at all-ones, further errors still pulse err but the count does not wrap.
- exp_code wrap: 6→0 is treated as a normal correct transition, not an error.

Decomposition:
- Package seq0356_pkg holds:
  - localparam codes C0=4'd0, C1=4'd3, C2=4'd5, C3=4'd6;
  - the state enum typedef {HUNT, SYNC, LOCKED, LOSS};
  - function next_code(4-bit) → 4-bit;
  - function is_legal(4-bit) → bit;
  - function decode(4-bit) → 2-bit.
- One sub-module, sat_counter (params W; ports clk, clear, inc, count), for err_count.
- The FSM and the good/bad counters stay in the top module.

Test Plan (defaults LOCK_COUNT=4, UNLOCK_ERRS=2, ERR_CNT_W=8):
- Acquisition: clear 1 cycle, then valid=1 with codes 0,3,5,6,0,3 → idx_valid=1 each cycle; idx=0,1,2,3,0,1; locked rises one cycle after the 4th sample (6); err stays 0.
- Single error with flywheel: locked, then 0,3,9,6,0 → err pulses once (after the 9), err_count=1, err_sticky=1, locked stays 1, 6 is accepted as correct, state back to LOCKED.
- Loss of lock: locked, then 0,3,0,0 → two errors, err_count=2, locked falls one cycle after the 2nd error; the next 0,3,5,6 re-locks with err_count still 2.
- Acquisition restart: from reset, 0,3,6,0,3,5 → no err; restart at 6 (good_cnt=1); locked rises after the 5 (4th correct: 6,0,3,5).
- Gaps and clear priority: locked stream with valid toggling 1,0,1 → FSM holds and idx_valid=0 during the gap. Assert clear and valid with code 3 in the same cycle → next cycle all outputs 0, state HUNT.
- Saturation (ERR_CNT_W=2): 5 counted errors (using UNLOCK_ERRS=15) → err_count reads 1,2,3,3,3; err pulses 5 times.
